// File: rtl/bus_cycle_master_if.sv
// bus_cycle_master_if: request/response handshake and local-bus control signals.
interface bus_cycle_master_if #(
    parameter int ADDR_BITS = 20,
    parameter int DATA_BITS = 8
) ();
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic                 req_iom;
    logic [ADDR_BITS-1:0] req_addr;
    logic [DATA_BITS-1:0] req_wdata;
    logic                 rsp_valid;
    logic [DATA_BITS-1:0] rsp_rdata;
    logic                 rsp_err;
    logic                 CS;
    logic                 ALE;
    logic                 RD_N;
    logic                 WR_N;
    logic                 IOM;
    logic [ADDR_BITS-1:0] Address;

    modport master (
        input  req_valid, req_write, req_iom, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output CS, ALE, RD_N, WR_N, IOM, Address
    );

    modport slave (
        output req_valid, req_write, req_iom, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  CS, ALE, RD_N, WR_N, IOM, Address
    );
endinterface

// File: rtl/bus_cycle_master.sv
// bus_cycle_master: runs one T1..T4 local-bus cycle per accepted single-beat request.
module bus_cycle_master #(
    parameter int                   ADDR_BITS = 20,
    parameter int                   DATA_BITS = 8,
    parameter logic [ADDR_BITS-1:0] CS_BASE   = '0,
    parameter logic [ADDR_BITS-1:0] CS_LIMIT  = '1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    bus_cycle_master_if.master    bus,
    inout  wire  [DATA_BITS-1:0]  Data
);
    typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;

    state_t               state, nxt;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] wdata_q, rdata_q;
    logic                 write_q, iom_q, hit_q, err_q;
    logic                 accept, strobe, drive, hit;
    logic [ADDR_BITS:0]   lo_d, hi_d;

    // borrow-out of the extended subtractions gives the range test without constant-compare warnings
    assign lo_d   = {1'b0, bus.req_addr} - {1'b0, CS_BASE};
    assign hi_d   = {1'b0, CS_LIMIT} - {1'b0, bus.req_addr};
    assign hit    = !lo_d[ADDR_BITS] && !hi_d[ADDR_BITS];
    assign accept = bus.req_valid && bus.req_ready;

    always_ff @(posedge CLK) begin
        state <= RESET ? IDLE : nxt;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            iom_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else if (accept) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            write_q <= bus.req_write;
            iom_q   <= bus.req_iom;
            hit_q   <= hit;
        end
    end

    // a miss never samples the floating bus
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state == T3) begin
            err_q <= !hit_q;
            if (!write_q) rdata_q <= hit_q ? Data : '0;
        end
    end

    always_comb begin
        nxt = (state == IDLE || state == T4) ? (accept ? T1 : IDLE) :
              state == T1 ? T2 :
              state == T2 ? T3 :
              state == T3 ? T4 : IDLE;
    end

    always_comb begin
        strobe        = state == T2 || state == T3;
        drive         = strobe && write_q;
        bus.req_ready = state == IDLE || state == T4;
        bus.ALE       = state == T1;
        bus.CS        = hit_q && state != IDLE;
        bus.RD_N      = !(strobe && !write_q);
        bus.WR_N      = !drive;
        bus.IOM       = iom_q;
        bus.Address   = addr_q;
        bus.rsp_valid = state == T4;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
    end

    assign Data = drive ? wdata_q : 'z;
endmodule

// File: tb/tb_bus_cycle_master.sv
// tb_bus_cycle_master: directed checks of bus_cycle_master against a behavioural memory slave.
module tb_bus_cycle_master;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       pre_en = 1'b0;
    logic [7:0] pre_a = '0, pre_d = '0, old;
    logic [7:0] mem [0:255];
    logic [2:0] sst;
    logic       sdrive;
    wire  [7:0] data;
    int         tests = 0, fails = 0, ph = 0;
    logic [19:0] aref = '0;

    always #5 CLK = ~CLK;

    bus_cycle_master_if #(.ADDR_BITS(20), .DATA_BITS(8)) bus ();

    bus_cycle_master #(
        .ADDR_BITS(20), .DATA_BITS(8), .CS_BASE(20'h00000), .CS_LIMIT(20'h0FFFF)
    ) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus), .Data(data)
    );

    // an undriven bus reads as 8'hFF, which is how release to 'z is observed
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (data[i]);
    end

    assign sdrive = bus.CS && !bus.RD_N;
    assign data   = sdrive ? mem[bus.Address[7:0]] : 'z;

    // slave: sst 0 = waiting in T1, 2/3/4 = following T2/T3/T4; loads at the T3->T4 edge
    always @(posedge CLK) begin
        if (pre_en) mem[pre_a] <= pre_d;
        if (RESET) sst <= 3'd0;
        else if (sst == 3'd0) sst <= (bus.ALE && bus.CS) ? 3'd2 : 3'd0;
        else if (sst == 3'd2) sst <= 3'd3;
        else if (sst == 3'd3) begin
            if (!bus.WR_N) mem[bus.Address[7:0]] <= data;
            sst <= 3'd4;
        end else sst <= 3'd0;
    end

    always @(negedge CLK) begin
        tests++;
        assert (!(!bus.RD_N && !bus.WR_N)) else begin
            fails++;
            $error("FAIL strobe_overlap: RD_N=%0b WR_N=%0b required not both 0", bus.RD_N, bus.WR_N);
        end
        if (!bus.RD_N) begin
            tests++;
            assert (data === (sdrive ? mem[bus.Address[7:0]] : 8'hFF)) else begin
                fails++;
                $error("FAIL rd_contention: Data=%0h required %0h", data, sdrive ? mem[bus.Address[7:0]] : 8'hFF);
            end
        end
        if (ph != 0 && !bus.ALE) begin
            tests++;
            assert (bus.Address === aref) else begin
                fails++;
                $error("FAIL addr_stable: Address=%0h required %0h", bus.Address, aref);
            end
        end
        if (bus.ALE) aref = bus.Address;
        ph = RESET ? 0 : bus.ALE ? 1 : (ph == 0 || ph == 3) ? 0 : ph + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic w, input logic iom, input logic [19:0] a, input logic [7:0] d);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_iom   = iom;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_iom   = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            pre_en = 1'b1;
            pre_a  = i == 0 ? 8'h10 : 8'(i);
            pre_d  = i == 0 ? 8'hA5 : 8'(8'h11 * i);
            tick();
        end
        pre_en = 1'b0;
        chk("rst_ale", bus.ALE, 0);
        chk("rst_cs", bus.CS, 0);
        chk("rst_rd_n", bus.RD_N, 1);
        chk("rst_wr_n", bus.WR_N, 1);
        chk("rst_iom", bus.IOM, 0);
        chk("rst_addr", bus.Address, 0);
        chk("rst_data_z", data, 8'hFF);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_rdata", bus.rsp_rdata, 0);
        chk("rst_ready", bus.req_ready, 1);
        RESET = 1'b0;
        tick();

        req(1'b0, 1'b1, 20'h00010, 8'h00);
        tick();
        bus.req_valid = 1'b0;
        chk("rh_t1_ale", bus.ALE, 1);
        chk("rh_t1_cs", bus.CS, 1);
        chk("rh_t1_iom", bus.IOM, 1);
        chk("rh_t1_addr", bus.Address, 20'h00010);
        chk("rh_t1_rd_n", bus.RD_N, 1);
        chk("rh_t1_ready", bus.req_ready, 0);
        tick();
        chk("rh_t2_ale", bus.ALE, 0);
        chk("rh_t2_rd_n", bus.RD_N, 0);
        chk("rh_t2_rsp_valid", bus.rsp_valid, 0);
        tick();
        chk("rh_t3_rd_n", bus.RD_N, 0);
        chk("rh_t3_rsp_valid", bus.rsp_valid, 0);
        tick();
        chk("rh_t4_rd_n", bus.RD_N, 1);
        chk("rh_t4_rsp_valid", bus.rsp_valid, 1);
        chk("rh_rdata", bus.rsp_rdata, 8'hA5);
        chk("rh_err", bus.rsp_err, 0);
        chk("rh_t4_ready", bus.req_ready, 1);
        tick();
        chk("rh_idle_rsp_valid", bus.rsp_valid, 0);
        chk("rh_idle_cs", bus.CS, 0);
        chk("rh_idle_addr_held", bus.Address, 20'h00010);

        req(1'b1, 1'b0, 20'h00020, 8'h3C);
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = 20'h00033;
        bus.req_wdata = 8'h55;
        chk("wr_t1_wr_n", bus.WR_N, 1);
        chk("wr_t1_data_z", data, 8'hFF);
        tick();
        chk("wr_t2_wr_n", bus.WR_N, 0);
        chk("wr_t2_rd_n", bus.RD_N, 1);
        chk("wr_t2_data", data, 8'h3C);
        chk("wr_t2_addr", bus.Address, 20'h00020);
        tick();
        chk("wr_t3_wr_n", bus.WR_N, 0);
        chk("wr_t3_data", data, 8'h3C);
        tick();
        chk("wr_t4_wr_n", bus.WR_N, 1);
        chk("wr_t4_data_z", data, 8'hFF);
        chk("wr_t4_rsp_valid", bus.rsp_valid, 1);
        chk("wr_t4_err", bus.rsp_err, 0);
        chk("wr_mem", mem[8'h20], 8'h3C);
        req(1'b0, 1'b0, 20'h00020, 8'h00);
        tick();
        bus.req_valid = 1'b0;
        chk("wr_rb_t1_ale", bus.ALE, 1);
        tick();
        tick();
        tick();
        chk("wr_rb_rsp_valid", bus.rsp_valid, 1);
        chk("wr_rb_rdata", bus.rsp_rdata, 8'h3C);
        tick();

        req(1'b0, 1'b0, 20'h00001, 8'h00);
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("b2b_ale_%0d", c), bus.ALE, c % 4 == 1);
            chk($sformatf("b2b_rsp_valid_%0d", c), bus.rsp_valid, c % 4 == 0);
            if (c % 4 == 0) begin
                chk($sformatf("b2b_rdata_%0d", c), bus.rsp_rdata, 8'h11 * (c / 4));
                bus.req_addr = 20'(c / 4 + 1);
                if (c == 12) bus.req_valid = 1'b0;
            end
        end
        tick();
        chk("b2b_idle_ale", bus.ALE, 0);
        chk("b2b_idle_rsp_valid", bus.rsp_valid, 0);

        req(1'b0, 1'b0, 20'h10000, 8'h00);
        tick();
        bus.req_valid = 1'b0;
        chk("miss_t1_cs", bus.CS, 0);
        chk("miss_t1_ale", bus.ALE, 1);
        tick();
        chk("miss_t2_cs", bus.CS, 0);
        chk("miss_t2_rd_n", bus.RD_N, 0);
        chk("miss_slave_t2", sst, 0);
        tick();
        chk("miss_t3_cs", bus.CS, 0);
        tick();
        chk("miss_rsp_valid", bus.rsp_valid, 1);
        chk("miss_err", bus.rsp_err, 1);
        chk("miss_rdata", bus.rsp_rdata, 0);
        chk("miss_slave_t4", sst, 0);
        tick();

        old = mem[8'h40];
        req(1'b1, 1'b0, 20'h00040, 8'h77);
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("rst_mid_t2_wr_n", bus.WR_N, 0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("rst_mid_wr_n", bus.WR_N, 1);
        chk("rst_mid_data_z", data, 8'hFF);
        chk("rst_mid_ready", bus.req_ready, 1);
        chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rst_mid_no_rsp_%0d", k), bus.rsp_valid, 0);
        end
        chk("rst_mid_mem", mem[8'h40], old);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
